// File: rtl/rv32im_pkg.sv
// Shared RV32IM decode definitions: encodings, ALU/branch/M op codes and the
// registered decode bundle carried between the decoder and the stage buffers.
package rv32im_pkg;

  localparam int unsigned XLEN_W   = 32;
  localparam int unsigned INST_W   = 32;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned REG_W    = 5;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  // BR_NONE is zero so non-branches carry a zero branch op.
  typedef enum logic [ALU_OP_W-1:0] {
    BR_NONE = 4'd0,
    BR_EQ   = 4'd1,
    BR_NEQ  = 4'd2,
    BR_LT   = 4'd3,
    BR_GE   = 4'd4,
    BR_LTU  = 4'd5,
    BR_GEU  = 4'd6
  } br_op_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef struct packed {
    logic [XLEN_W-1:0] pc;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [31:0]       imm;
    alu_op_e           alu_op;
    br_op_e            branch_op;
    logic              is_md;
    md_op_e            md_op;
    logic              rd_we;
    logic              illegal;
  } decode_bundle_t;

  // Shared OP / OP-IMM funct3 mapping; sub/sra select the funct7[5] variants.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic sub,
                                          input logic sra);
    alu_op_e op;
    case (f3)
      F3_ADD_SUB: op = sub ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = sra ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32im_decode_stage_if.sv
// Decode-stage bus: upstream instruction handshake plus downstream decoded bundle.
// slave = the decode stage, master = the environment driving/consuming it.
interface rv32im_decode_stage_if #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned ALU_OP_WIDTH = 4
);
  import rv32im_pkg::*;

  logic                    i_valid;
  logic                    o_ready;
  logic [INST_W-1:0]       i_inst;
  logic [XLEN-1:0]         i_pc;
  logic                    o_valid;
  logic                    i_ready;
  logic [XLEN-1:0]         o_pc;
  logic [6:0]              o_opcode;
  logic [2:0]              o_funct3;
  logic [REG_W-1:0]        o_rs1_addr;
  logic [REG_W-1:0]        o_rs2_addr;
  logic [REG_W-1:0]        o_rd_addr;
  logic [31:0]             o_imm;
  logic [ALU_OP_WIDTH-1:0] o_alu_op;
  logic [ALU_OP_WIDTH-1:0] o_branch_op;
  logic                    o_is_md;
  logic [2:0]              o_md_op;
  logic                    o_rd_we;
  logic                    o_illegal;

  modport slave (
    input  i_valid, i_inst, i_pc, i_ready,
    output o_ready, o_valid, o_pc, o_opcode, o_funct3, o_rs1_addr, o_rs2_addr,
           o_rd_addr, o_imm, o_alu_op, o_branch_op, o_is_md, o_md_op, o_rd_we,
           o_illegal
  );

  modport master (
    output i_valid, i_inst, i_pc, i_ready,
    input  o_ready, o_valid, o_pc, o_opcode, o_funct3, o_rs1_addr, o_rs2_addr,
           o_rd_addr, o_imm, o_alu_op, o_branch_op, o_is_md, o_md_op, o_rd_we,
           o_illegal
  );
endinterface

// File: rtl/rv32im_decode_comb.sv
// Pure combinational RV32I(+M) decoder.
// Ports: inst/pc in, bundle_c out (unregistered decode bundle).
module rv32im_decode_comb
  import rv32im_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [INST_W-1:0] inst,
  input  logic [XLEN_W-1:0] pc,
  output decode_bundle_t    bundle_c
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    bundle_c           = '0;
    bundle_c.pc        = pc;
    bundle_c.opcode    = opcode;
    bundle_c.funct3    = f3;
    bundle_c.rs1       = inst[19:15];
    bundle_c.rs2       = inst[24:20];
    bundle_c.rd        = inst[11:7];
    bundle_c.alu_op    = ALU_ADD;
    bundle_c.branch_op = BR_NONE;
    bundle_c.md_op     = MD_MUL;
    bundle_c.illegal   = (inst[1:0] != 2'b11);

    case (opcode)
      OPC_LUI: begin
        bundle_c.imm    = imm_u;
        bundle_c.alu_op = ALU_LUI;
      end
      OPC_AUIPC: bundle_c.imm = imm_u;
      OPC_JAL:   bundle_c.imm = imm_j;
      OPC_JALR:  bundle_c.imm = imm_i;
      OPC_BRANCH: begin
        bundle_c.imm = imm_b;
        case (f3)
          3'b000:  bundle_c.branch_op = BR_EQ;
          3'b001:  bundle_c.branch_op = BR_NEQ;
          3'b100:  bundle_c.branch_op = BR_LT;
          3'b101:  bundle_c.branch_op = BR_GE;
          3'b110:  bundle_c.branch_op = BR_LTU;
          3'b111:  bundle_c.branch_op = BR_GEU;
          default: bundle_c.illegal   = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        bundle_c.imm = imm_i;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) bundle_c.illegal = 1'b1;
      end
      OPC_STORE: begin
        bundle_c.imm = imm_s;
        if (f3 >= 3'b011) bundle_c.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        bundle_c.imm    = imm_i;
        bundle_c.alu_op = alu_from_f3(f3, 1'b0, inst[30]);
        // Shift immediates reuse the funct7 field; only SRAI may set bit 30.
        if ((f3 == F3_SLL || f3 == F3_SRL_SRA) &&
            !(f7 == F7_BASE || (f7 == F7_ALT && f3 == F3_SRL_SRA)))
          bundle_c.illegal = 1'b1;
      end
      OPC_OP: begin
        if (f7 == F7_MULDIV) begin
          if (ENABLE_M) begin
            bundle_c.is_md = 1'b1;
            bundle_c.md_op = md_op_e'(f3);
          end else begin
            bundle_c.illegal = 1'b1;
          end
        end else if (f7 == F7_BASE) begin
          bundle_c.alu_op = alu_from_f3(f3, 1'b0, 1'b0);
        end else if (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA)) begin
          bundle_c.alu_op = alu_from_f3(f3, 1'b1, 1'b1);
        end else begin
          bundle_c.illegal = 1'b1;
        end
      end
      OPC_MISC_MEM, OPC_SYSTEM: ;
      default: bundle_c.illegal = 1'b1;
    endcase

    if (bundle_c.illegal) begin
      bundle_c.is_md = 1'b0;
      bundle_c.md_op = MD_MUL;
    end

    bundle_c.rd_we = !bundle_c.illegal && (bundle_c.rd != '0) &&
                     !(opcode inside {OPC_STORE, OPC_BRANCH, OPC_MISC_MEM, OPC_SYSTEM});
  end

endmodule

// File: rtl/rv32im_decode_stage.sv
// Registered RV32IM decode stage with an output register plus one skid entry,
// giving full throughput behind a registered o_ready.
// Ports: i_clk, i_rst (sync, active-high), i_flush, bus (slave: upstream
// valid/ready/inst/pc in, downstream valid/ready and decoded bundle out).
module rv32im_decode_stage
  import rv32im_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter bit          ENABLE_M     = 1'b1,
  parameter int unsigned ALU_OP_WIDTH = 4
) (
  input logic                 i_clk,
  input logic                 i_rst,
  input logic                 i_flush,
  rv32im_decode_stage_if.slave bus
);

  if (XLEN != 32) begin : g_xlen_check
    $error("rv32im_decode_stage supports only XLEN=32");
  end
  if (ALU_OP_WIDTH < ALU_OP_W) begin : g_alu_w_check
    $error("rv32im_decode_stage needs ALU_OP_WIDTH >= 4");
  end

  decode_bundle_t dec_c;
  decode_bundle_t out_q, out_d, skid_q, skid_d;
  logic           out_valid_q, out_valid_d;
  logic           skid_valid_q, skid_valid_d;
  logic           ready_q;
  logic           accept;

  rv32im_decode_comb #(.ENABLE_M(ENABLE_M)) u_decode (
    .inst     (bus.i_inst),
    .pc       (32'(bus.i_pc)),
    .bundle_c (dec_c)
  );

  // Next-state for the out/skid pair; flush wins over everything else.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    accept       = bus.i_valid && !skid_valid_q && !i_flush;

    if (i_flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_valid_q && !bus.i_ready) begin
      // Out register stalled: park a new bundle in skid (skid is empty if accept).
      if (accept) begin
        skid_d       = dec_c;
        skid_valid_d = 1'b1;
      end
    end else if (skid_valid_q) begin
      out_d        = skid_q;
      out_valid_d  = 1'b1;
      skid_valid_d = 1'b0;
    end else begin
      out_valid_d = accept;
      if (accept) out_d = dec_c;
    end
  end

  // o_ready is registered as the inverse of the next skid occupancy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= !skid_valid_d;
    end
  end

  assign bus.o_ready     = ready_q;
  assign bus.o_valid     = out_valid_q;
  assign bus.o_pc        = XLEN'(out_q.pc);
  assign bus.o_opcode    = out_q.opcode;
  assign bus.o_funct3    = out_q.funct3;
  assign bus.o_rs1_addr  = out_q.rs1;
  assign bus.o_rs2_addr  = out_q.rs2;
  assign bus.o_rd_addr   = out_q.rd;
  assign bus.o_imm       = out_q.imm;
  assign bus.o_alu_op    = ALU_OP_WIDTH'(out_q.alu_op);
  assign bus.o_branch_op = ALU_OP_WIDTH'(out_q.branch_op);
  assign bus.o_is_md     = out_q.is_md;
  assign bus.o_md_op     = 3'(out_q.md_op);
  assign bus.o_rd_we     = out_q.rd_we;
  assign bus.o_illegal   = out_q.illegal;

endmodule

// File: tb/tb_rv32im_decode_stage.sv
// Bench for rv32im_decode_stage: directed decode table plus backpressure and
// flush sequences. A second instance with ENABLE_M=0 sees the same stream.
module tb_rv32im_decode_stage;
  import rv32im_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  rv32im_decode_stage_if #(.XLEN(32), .ALU_OP_WIDTH(4)) bus ();
  rv32im_decode_stage_if #(.XLEN(32), .ALU_OP_WIDTH(4)) bus_nm ();

  rv32im_decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .ALU_OP_WIDTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .bus(bus)
  );
  rv32im_decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .ALU_OP_WIDTH(4)) dut_nm (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .bus(bus_nm)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    bit          nom;      // check the ENABLE_M=0 instance
    bit          chk_ops;  // also check imm / alu / branch
    logic [31:0] imm;
    alu_op_e     alu;
    br_op_e      br;
    bit          is_md;
    logic [2:0]  md;
    bit          rd_we;
    bit          ill;
    logic [4:0]  rd;
  } vec_t;

  localparam int NV = 16;
  vec_t v[NV];

  function automatic vec_t mk(input logic [31:0] inst, input bit nom, input bit chk_ops,
                              input logic [31:0] imm, input alu_op_e alu, input br_op_e br,
                              input bit is_md, input logic [2:0] md, input bit rd_we,
                              input bit ill, input logic [4:0] rd);
    vec_t r;
    r.inst = inst; r.nom = nom; r.chk_ops = chk_ops; r.imm = imm; r.alu = alu;
    r.br = br; r.is_md = is_md; r.md = md; r.rd_we = rd_we; r.ill = ill; r.rd = rd;
    return r;
  endfunction

  // Completed downstream handshakes (flush cycles excluded).
  logic [31:0] mon_q[$];
  bit          mon_en = 1'b0;
  always @(posedge clk)
    if (mon_en && !rst && !flush && bus.o_valid && bus.i_ready) mon_q.push_back(bus.o_pc);

  task automatic drive(input logic valid, input logic [31:0] inst, input logic [31:0] pc);
    bus.i_valid    = valid; bus.i_inst    = inst; bus.i_pc    = pc;
    bus_nm.i_valid = valid; bus_nm.i_inst = inst; bus_nm.i_pc = pc;
  endtask

  task automatic set_ready(input logic r);
    bus.i_ready    = r;
    bus_nm.i_ready = r;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic        a_valid, a_ready, a_is_md, a_rd_we, a_ill;
  logic [31:0] a_pc, a_imm;
  logic [3:0]  a_alu, a_br;
  logic [2:0]  a_md;
  logic [4:0]  a_rd;

  initial begin
    v[0]  = mk(32'h00500093, 0, 1, 32'd5,        ALU_ADD, BR_NONE, 0, 3'd0, 1, 0, 5'd1);
    v[1]  = mk(32'h40208133, 0, 1, 32'd0,        ALU_SUB, BR_NONE, 0, 3'd0, 1, 0, 5'd2);
    v[2]  = mk(32'h022081B3, 0, 1, 32'd0,        ALU_ADD, BR_NONE, 1, 3'd0, 1, 0, 5'd3);
    v[3]  = mk(32'hFE000EE3, 0, 1, 32'hFFFFFFFC, ALU_ADD, BR_EQ,   0, 3'd0, 0, 0, 5'd29);
    v[4]  = mk(32'h800000EF, 0, 1, 32'hFFF00000, ALU_ADD, BR_NONE, 0, 3'd0, 1, 0, 5'd1);
    v[5]  = mk(32'h0220C1B3, 1, 0, 32'd0,        ALU_ADD, BR_NONE, 0, 3'd0, 0, 1, 5'd3);
    v[6]  = mk(32'h0000207F, 0, 0, 32'd0,        ALU_ADD, BR_NONE, 0, 3'd0, 0, 1, 5'd0);
    v[7]  = mk(32'h4020D093, 0, 1, 32'h00000402, ALU_SRA, BR_NONE, 0, 3'd0, 1, 0, 5'd1);
    v[8]  = mk(32'h123452B7, 0, 1, 32'h12345000, ALU_LUI, BR_NONE, 0, 3'd0, 1, 0, 5'd5);
    v[9]  = mk(32'h0020A423, 0, 1, 32'd8,        ALU_ADD, BR_NONE, 0, 3'd0, 0, 0, 5'd8);
    v[10] = mk(32'h00000033, 0, 1, 32'd0,        ALU_ADD, BR_NONE, 0, 3'd0, 0, 0, 5'd0);
    v[11] = mk(32'h00003083, 0, 0, 32'd0,        ALU_ADD, BR_NONE, 0, 3'd0, 0, 1, 5'd1);
    v[12] = mk(32'h00002063, 0, 0, 32'd0,        ALU_ADD, BR_NONE, 0, 3'd0, 0, 1, 5'd0);
    v[13] = mk(32'h40001033, 0, 0, 32'd0,        ALU_ADD, BR_NONE, 0, 3'd0, 0, 1, 5'd0);
    v[14] = mk(32'h0220D1B3, 0, 1, 32'd0,        ALU_ADD, BR_NONE, 1, 3'd5, 1, 0, 5'd3);
    v[15] = mk(32'h40001013, 0, 0, 32'd0,        ALU_ADD, BR_NONE, 0, 3'd0, 0, 1, 5'd0);

    rst = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    set_ready(1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset.o_valid", 32'(bus.o_valid), 32'd0);
    chk("reset.o_imm",   bus.o_imm,        32'd0);
    chk("reset.o_ready", 32'(bus.o_ready), 32'd1);
    chk("reset.o_illegal", 32'(bus.o_illegal), 32'd0);

    // Back-to-back streaming, one vector per cycle, result one cycle later.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(1'b1, v[i].inst, 32'(i * 4));
      tick();
      if (v[i].nom) begin
        a_valid = bus_nm.o_valid; a_ready = bus_nm.o_ready; a_pc = bus_nm.o_pc;
        a_imm = bus_nm.o_imm; a_alu = bus_nm.o_alu_op; a_br = bus_nm.o_branch_op;
        a_is_md = bus_nm.o_is_md; a_md = bus_nm.o_md_op; a_rd_we = bus_nm.o_rd_we;
        a_ill = bus_nm.o_illegal; a_rd = bus_nm.o_rd_addr;
      end else begin
        a_valid = bus.o_valid; a_ready = bus.o_ready; a_pc = bus.o_pc;
        a_imm = bus.o_imm; a_alu = bus.o_alu_op; a_br = bus.o_branch_op;
        a_is_md = bus.o_is_md; a_md = bus.o_md_op; a_rd_we = bus.o_rd_we;
        a_ill = bus.o_illegal; a_rd = bus.o_rd_addr;
      end
      chk($sformatf("v%0d.valid", i),   32'(a_valid), 32'd1);
      chk($sformatf("v%0d.ready", i),   32'(a_ready), 32'd1);
      chk($sformatf("v%0d.pc", i),      a_pc,         32'(i * 4));
      chk($sformatf("v%0d.is_md", i),   32'(a_is_md), 32'(v[i].is_md));
      chk($sformatf("v%0d.md_op", i),   32'(a_md),    32'(v[i].md));
      chk($sformatf("v%0d.rd_we", i),   32'(a_rd_we), 32'(v[i].rd_we));
      chk($sformatf("v%0d.illegal", i), 32'(a_ill),   32'(v[i].ill));
      chk($sformatf("v%0d.rd", i),      32'(a_rd),    32'(v[i].rd));
      if (v[i].chk_ops) begin
        chk($sformatf("v%0d.imm", i), a_imm,       v[i].imm);
        chk($sformatf("v%0d.alu", i), 32'(a_alu),  32'(v[i].alu));
        chk($sformatf("v%0d.br", i),  32'(a_br),   32'(v[i].br));
      end
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("drain.o_valid", 32'(bus.o_valid), 32'd0);

    // Backpressure: three sends while i_ready=0, then release.
    mon_q.delete();
    mon_en = 1'b1;
    @(negedge clk);
    set_ready(1'b0);
    drive(1'b1, 32'h00500093, 32'h0);
    tick();
    chk("bp.first.valid", 32'(bus.o_valid), 32'd1);
    chk("bp.first.pc",    bus.o_pc,         32'h0);
    chk("bp.first.ready", 32'(bus.o_ready), 32'd1);
    @(negedge clk);
    drive(1'b1, 32'h40208133, 32'h4);
    tick();
    chk("bp.skid.ready", 32'(bus.o_ready), 32'd0);
    chk("bp.skid.pc",    bus.o_pc,         32'h0);
    chk("bp.skid.imm",   bus.o_imm,        32'd5);
    @(negedge clk);
    drive(1'b1, 32'h022081B3, 32'h8);
    tick();
    chk("bp.hold.ready", 32'(bus.o_ready), 32'd0);
    chk("bp.hold.pc",    bus.o_pc,         32'h0);
    chk("bp.hold.valid", 32'(bus.o_valid), 32'd1);
    @(negedge clk);
    set_ready(1'b1);
    tick();
    chk("bp.rel1.pc",    bus.o_pc,         32'h4);
    chk("bp.rel1.alu",   32'(bus.o_alu_op), 32'(ALU_SUB));
    chk("bp.rel1.ready", 32'(bus.o_ready), 32'd1);
    tick();
    chk("bp.rel2.pc",    bus.o_pc,         32'h8);
    chk("bp.rel2.is_md", 32'(bus.o_is_md), 32'd1);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("bp.end.valid", 32'(bus.o_valid), 32'd0);
    chk("bp.order.count", 32'(mon_q.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("bp.order%0d", k), (k < mon_q.size()) ? mon_q[k] : 32'hDEAD_BEEF,
          32'(k * 4));

    // Flush with out and skid both full and a new instruction presented.
    mon_q.delete();
    @(negedge clk);
    set_ready(1'b0);
    drive(1'b1, 32'h00500093, 32'h100);
    tick();
    @(negedge clk);
    drive(1'b1, 32'h00500093, 32'h104);
    tick();
    chk("fl.full.ready", 32'(bus.o_ready), 32'd0);
    @(negedge clk);
    flush = 1'b1;
    set_ready(1'b1);
    drive(1'b1, 32'h00500093, 32'h108);
    tick();
    chk("fl.valid", 32'(bus.o_valid), 32'd0);
    chk("fl.ready", 32'(bus.o_ready), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b1, 32'h4020D093, 32'h200);
    tick();
    chk("fl.after.valid", 32'(bus.o_valid), 32'd1);
    chk("fl.after.pc",    bus.o_pc,         32'h200);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("fl.after.drain", 32'(bus.o_valid), 32'd0);
    chk("fl.seen.count", 32'(mon_q.size()), 32'd1);
    chk("fl.seen.pc", (mon_q.size() > 0) ? mon_q[0] : 32'hDEAD_BEEF, 32'h200);
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
